// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small circular byte FIFO.
// Bytes are popped into the shifter from IDLE and sent LSB first with a registered line output.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_transmit,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;

    localparam logic [TW-1:0] TimerLast = TW'(DIV - 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic full, empty, pop, push_ok, drop, timer_done;

    assign full       = (count_q == CountFull);
    assign empty      = (count_q == '0);
    assign timer_done = (timer_q == TimerLast);

    // Pop decision uses the registered count, so a push into an empty FIFO is seen a cycle later.
    assign pop     = (state_q == StIdle) && !empty;
    assign push_ok = i_tx_transmit && (!full || pop);
    assign drop    = i_tx_transmit && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_done) begin
                    timer_d = '0;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StData: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StStop: begin
                if (timer_done) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is derived from the next state so the register lines up with the FSM.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_tx_data;
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = (state_q != StIdle);
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level queue model checked every cycle, plus literal timing pins.
module tb_uart_tx_fifo;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_transmit = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, busy, full, empty, overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_fifo #(
        .CLK_HZ (16),
        .BAUD   (1),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tx_transmit (tx_transmit),
        .i_tx_data     (tx_data),
        .o_tx          (tx),
        .o_busy        (busy),
        .o_full        (full),
        .o_empty       (empty),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a byte queue and a frame position t; a frame is 10 slots of DIV clocks.
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 0;
    int         m_sz;
    bit         m_pop;
    int         m_slot;
    logic       m_tx;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
        end else begin
            m_slot = m_t / DIV;
            if (!m_active)        m_tx = 1'b1;
            else if (m_slot == 0) m_tx = 1'b0;
            else if (m_slot <= 8) m_tx = m_byte[m_slot-1];
            else                  m_tx = 1'b1;
            chk("m_tx", tx, m_tx);
            chk("m_busy", busy, m_active);
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_empty", empty, mq.size() == 0);
            chk("m_overflow", overflow, m_ovf);

            m_sz  = mq.size();
            m_pop = !m_active && (m_sz > 0);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * DIV) m_active = 0;
            end
            if (m_pop) begin
                m_byte   = mq.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (tx_transmit) begin
                if (m_sz < DEPTH || m_pop) mq.push_back(tx_data);
                else m_ovf = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input logic [7:0] b);
        tx_transmit = 1'b1;
        tx_data     = b;
        tick();
        tx_transmit = 1'b0;
        tx_data     = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int n, n2, frames;
    logic prev_busy;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Single byte 0x20: bits 0,0,0,0,0,1,0,0
        n = cyc;
        push(8'h20);
        go_to(n + 1);  chk("s1_tx_idle", tx, 1'b1);
        go_to(n + 2);  chk("s1_start0", tx, 1'b0);
        chk("s1_busy_on", busy, 1'b1);
        go_to(n + 17); chk("s1_start_end", tx, 1'b0);
        go_to(n + 98); chk("s1_bit5", tx, 1'b1);
        go_to(n + 114); chk("s1_bit6", tx, 1'b0);
        go_to(n + 146); chk("s1_stop", tx, 1'b1);
        go_to(n + 161); chk("s1_busy_last", busy, 1'b1);
        go_to(n + 162); chk("s1_busy_off", busy, 1'b0);
        go_to(n + 170);

        // Three back-to-back frames
        n = cyc;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        go_to(n + 2);   chk("s2_start1", tx, 1'b0);
        go_to(n + 162); chk("s2_gap_tx", tx, 1'b1);
        chk("s2_gap_busy", busy, 1'b0);
        go_to(n + 163); chk("s2_start2", tx, 1'b0);
        go_to(n + 323); chk("s2_not_empty", empty, 1'b0);
        go_to(n + 324); chk("s2_start3", tx, 1'b0);
        chk("s2_empty", empty, 1'b1);
        go_to(n + 485); chk("s2_done", busy, 1'b0);
        go_to(n + 490);

        // Overflow: six pushes, sixth dropped, five frames sent
        do_reset();
        n = cyc;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        chk("s3_full", full, 1'b1);
        chk("s3_ovf", overflow, 1'b1);
        frames = 1;
        prev_busy = busy;
        for (int i = 0; i < 5 * 161 + 20; i++) begin
            tick();
            if (busy && !prev_busy) frames++;
            prev_busy = busy;
        end
        chk("s3_frames", 8'(frames), 8'd5);
        chk("s3_empty", empty, 1'b1);
        chk("s3_ovf_sticky", overflow, 1'b1);

        // Push coinciding with the pop while full
        do_reset();
        n = cyc;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        go_to(n + 161); chk("s4_full", full, 1'b1);
        go_to(n + 162); chk("s4_idle", busy, 1'b0);
        push(8'h65);
        chk("s4_still_full", full, 1'b1);
        chk("s4_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 5 * 161 + 10; i++) tick();
        chk("s4_drained", empty, 1'b1);
        chk("s4_ovf_end", overflow, 1'b0);

        // Reset during DATA bit 3
        do_reset();
        n = cyc;
        push(8'hA5);
        push(8'h3C);
        go_to(n + 70); chk("s5_bit3", tx, 1'b0);
        chk("s5_queued", empty, 1'b0);
        rst = 1'b1;
        #1;
        chk("s5_rst_tx", tx, 1'b1);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_empty", empty, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        n2 = cyc;
        push(8'h5A);
        go_to(n2 + 2);   chk("s5_new_start", tx, 1'b0);
        go_to(n2 + 34);  chk("s5_new_bit1", tx, 1'b1);
        go_to(n2 + 162); chk("s5_new_done", busy, 1'b0);
        go_to(n2 + 170);

        // 0xFF then 0x00
        n = cyc;
        push(8'hFF);
        push(8'h00);
        go_to(n + 2);   chk("s6_start_ff", tx, 1'b0);
        go_to(n + 18);  chk("s6_ff_bit0", tx, 1'b1);
        go_to(n + 130); chk("s6_ff_bit7", tx, 1'b1);
        go_to(n + 146); chk("s6_ff_stop", tx, 1'b1);
        go_to(n + 163); chk("s6_start_00", tx, 1'b0);
        go_to(n + 179); chk("s6_00_bit0", tx, 1'b0);
        go_to(n + 291); chk("s6_00_bit7", tx, 1'b0);
        go_to(n + 307); chk("s6_00_stop", tx, 1'b1);
        go_to(n + 323); chk("s6_done", busy, 1'b0);
        go_to(n + 330);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
